counter_sequencer: RTL

Command-driven controller for a synchronous WIDTH-bit up/down counter. It accepts load, clear, count-up-N and count-down-N commands over a valid/ready handshake and steps the count once per clock. It signals completion with a one-cycle pulse. It sits between a host/test sequencer and the counter datapath, replacing free-running counters with commanded, bounded runs.

---
 rtl/counter_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven controller for a WIDTH-bit up/down counter.
// Commands (LOAD, UP N, DOWN N, CLEAR) arrive over a valid/ready handshake.
// UP/DOWN runs step the count once per clock, and each completed command
// produces a one-cycle done pulse.
// Optional feature macro: SATURATE_EN. When it is defined, a run stops at the
// count limits instead of wrapping, and a sat pulse is raised with done.
module counter_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             sat
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic             dir_down_q, dir_down_d;
  logic             done_q, done_d;
`ifdef SATURATE_EN
  logic             sat_q, sat_d;
  logic             at_limit;
`endif

  // Next-state, next-count and completion pulses for the two-state controller.
  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    remaining_d = remaining_q;
    dir_down_d  = dir_down_q;
    done_d      = 1'b0;
`ifdef SATURATE_EN
    sat_d       = 1'b0;
    at_limit    = dir_down_q ? (q_q == '0) : (q_q == '1);
`endif
    case (state_q)
      ST_IDLE: begin
        // cmd_ready is high whenever the controller is idle.
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD: begin
              q_d    = cmd_arg;
              done_d = 1'b1;
            end
            OP_CLEAR: begin
              q_d    = '0;
              done_d = 1'b1;
            end
            default: begin
              // A zero-length UP/DOWN run completes immediately.
              if (cmd_arg == '0) begin
                done_d = 1'b1;
              end else begin
                remaining_d = cmd_arg;
                dir_down_d  = (cmd_op == OP_DOWN);
                state_d     = ST_RUN;
              end
            end
          endcase
        end
      end
      ST_RUN: begin
        if (abort) begin
          // Abort takes priority over the step and ends the run silently.
          state_d     = ST_IDLE;
          remaining_d = '0;
`ifdef SATURATE_EN
        end else if (at_limit) begin
          // This step would wrap, so hold q and end the run with a sat pulse.
          state_d     = ST_IDLE;
          remaining_d = '0;
          done_d      = 1'b1;
          sat_d       = 1'b1;
`endif
        end else begin
          q_d         = dir_down_q ? (q_q - WIDTH'(1)) : (q_q + WIDTH'(1));
          remaining_d = remaining_q - WIDTH'(1);
          if (remaining_q == WIDTH'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register the state with a synchronous reset that overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      q_q         <= '0;
      remaining_q <= '0;
      dir_down_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef SATURATE_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      remaining_q <= remaining_d;
      dir_down_q  <= dir_down_d;
      done_q      <= done_d;
`ifdef SATURATE_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign q         = q_q;
  assign busy      = (state_q == ST_RUN);
  assign cmd_ready = (state_q == ST_IDLE);
  assign done      = done_q;
`ifdef SATURATE_EN
  assign sat       = sat_q;
`else
  assign sat       = 1'b0;
`endif

endmodule
